render_framebuffer: RTL and testbench

RENDER_FRAMEBUFFER -- requirements
Module: render_framebuffer

---
 rtl/render_framebuffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_render_framebuffer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_framebuffer.sv
// -----------------------------------------------------------------------------
// render_framebuffer
//
// Purpose:
//   Frame store between a pixel renderer and a raster display. It covers one
//   rectangular region of the screen (START_X/START_Y, WIDTH x HEIGHT).
//   The renderer writes pixels by screen coordinate into the back buffer. The
//   display reads the front buffer by its own hcount/vcount.
//   When DOUBLE_BUF=1, two buffers are kept. Writing the last pixel of the
//   region arms a swap. The swap takes effect on the next new-frame pulse.
//   While a swap is armed, further writes are back-pressured.
//   When DOUBLE_BUF=0, a single buffer is shared by both ports. Reads are
//   read-first on an address collision.
//
// Ports:
//   clk_in     single clock
//   rst_in     asynchronous active-high reset (memory contents are kept)
//   wr_valid   renderer pixel valid
//   wr_ready   block accepts the write
//   wr_hcount  write x coordinate (11 bits)
//   wr_vcount  write y coordinate (10 bits)
//   wr_data    write pixel (PIXEL_W bits)
//   rd_hcount  display x coordinate
//   rd_vcount  display y coordinate
//   rd_active  display active-draw flag
//   rd_hsync   display horizontal sync
//   rd_vsync   display vertical sync
//   nf_in      one-cycle new-frame pulse from the display timing
//   pix_out    displayed pixel, LATENCY cycles after the read coordinate
//   hs_out     rd_hsync delayed by LATENCY
//   vs_out     rd_vsync delayed by LATENCY
//   swap_out   one-cycle pulse on a buffer swap
//   front_out  index of the buffer being displayed
// -----------------------------------------------------------------------------
module render_framebuffer #(
   parameter int                 START_X    = 390,
   parameter int                 START_Y    = 390,
   parameter int                 WIDTH      = 244,
   parameter int                 HEIGHT     = 375,
   parameter int                 PIXEL_W    = 12,
   parameter int                 LATENCY    = 2,
   parameter int                 DOUBLE_BUF = 1,
   parameter logic [PIXEL_W-1:0] BG_COLOR   = {PIXEL_W{1'b0}}
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [10:0]        wr_hcount,
   input  logic [9:0]         wr_vcount,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic [10:0]        rd_hcount,
   input  logic [9:0]         rd_vcount,
   input  logic               rd_active,
   input  logic               rd_hsync,
   input  logic               rd_vsync,
   input  logic               nf_in,
   output logic [PIXEL_W-1:0] pix_out,
   output logic               hs_out,
   output logic               vs_out,
   output logic               swap_out,
   output logic               front_out
);

   localparam int DEPTH  = WIDTH * HEIGHT;
   localparam int NBUF   = (DOUBLE_BUF != 0) ? 2 : 1;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Region bounds, kept at 32 bits so that coordinate maths never wraps.
   localparam logic [31:0] X_LO   = 32'(START_X);
   localparam logic [31:0] X_HI   = 32'(START_X + WIDTH);
   localparam logic [31:0] Y_LO   = 32'(START_Y);
   localparam logic [31:0] Y_HI   = 32'(START_Y + HEIGHT);
   localparam logic [31:0] LAST_X = 32'(START_X + WIDTH - 1);
   localparam logic [31:0] LAST_Y = 32'(START_Y + HEIGHT - 1);

   // True when a zero-extended screen coordinate lies inside the region.
   function automatic logic in_region(input logic [31:0] x, input logic [31:0] y);
      return (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
   endfunction

   // Linear word address of an in-region coordinate. The offset is formed at
   // full width. The region check is done on the coordinates, so only
   // in-region (and therefore in-range) results are ever used.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] full;
      full = (x - X_LO) + (y - Y_LO) * 32'(WIDTH);
      return ADDR_W'(full);
   endfunction

   // Storage: one array per buffer.
   logic [PIXEL_W-1:0] mem_r [NBUF][DEPTH];

   // Write-side control state.
   logic               front_r;
   logic               pending_r;
   logic               swap_r;
   logic               wr_ready_r;

   // Write-side combinational terms.
   logic [31:0]        wr_x_s;
   logic [31:0]        wr_y_s;
   logic               wr_fire_s;
   logic               wr_in_s;
   logic               wr_last_s;
   logic               swap_s;
   logic               wr_buf_s;
   logic [ADDR_W-1:0]  wr_addr_s;
   logic               pending_next_s;
   logic               front_next_s;
   logic               ready_next_s;

   // Read pipeline.
   // flag_pipe_r[j] is the in-region flag of stage j+1.
   // pix_pipe_r[j] is the pixel of stage j+2.
   logic [31:0]        rd_x_s;
   logic [31:0]        rd_y_s;
   logic               rd_in_s;
   logic [ADDR_W-1:0]  rd_addr_s;
   logic [ADDR_W-1:0]  rd_addr_r;
   logic               rd_front_r;
   logic               flag_pipe_r [LATENCY-1];
   logic [PIXEL_W-1:0] pix_pipe_r  [LATENCY-1];
   logic               hs_pipe_r   [LATENCY];
   logic               vs_pipe_r   [LATENCY];

   assign wr_x_s = {21'd0, wr_hcount};
   assign wr_y_s = {22'd0, wr_vcount};
   assign rd_x_s = {21'd0, rd_hcount};
   assign rd_y_s = {22'd0, rd_vcount};

   // Write handshake, last-pixel detection, swap decision and next control state.
   always_comb begin
      wr_fire_s      = wr_valid && wr_ready_r;
      wr_in_s        = in_region(wr_x_s, wr_y_s);
      wr_addr_s      = pix_addr(wr_x_s, wr_y_s);
      wr_last_s      = wr_fire_s && (wr_x_s == LAST_X) && (wr_y_s == LAST_Y);
      // The last-pixel write in the same cycle counts as pending. This lets
      // a coincident new-frame pulse swap at once. The write itself still
      // lands in the pre-swap back buffer, because wr_buf_s uses front_r.
      swap_s         = nf_in && (pending_r || wr_last_s);
      pending_next_s = pending_r;
      front_next_s   = front_r;

      if (swap_s) begin
         pending_next_s = 1'b0;
      end else if (wr_last_s) begin
         pending_next_s = 1'b1;
      end else begin
         pending_next_s = pending_r;
      end

      if (swap_s && (DOUBLE_BUF != 0)) begin
         front_next_s = ~front_r;
      end else begin
         front_next_s = front_r;
      end

      if (DOUBLE_BUF != 0) begin
         wr_buf_s     = ~front_r;
         ready_next_s = ~pending_next_s;
      end else begin
         wr_buf_s     = 1'b0;
         ready_next_s = 1'b1;
      end
   end

   // Control registers: buffer index, swap arm, swap pulse and write ready.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         front_r    <= 1'b0;
         pending_r  <= 1'b0;
         swap_r     <= 1'b0;
         wr_ready_r <= 1'b1;
      end else begin
         front_r    <= front_next_s;
         pending_r  <= pending_next_s;
         swap_r     <= swap_s;
         wr_ready_r <= ready_next_s;
      end
   end

   // Pixel store write port. Out-of-region handshakes are dropped here.
   always_ff @(posedge clk_in) begin
      if (wr_fire_s && wr_in_s) begin
         mem_r[wr_buf_s][wr_addr_s] <= wr_data;
      end
   end

   // Stage-1 address and in-region flag for the display read.
   always_comb begin
      rd_in_s = rd_active && in_region(rd_x_s, rd_y_s);
      if (rd_in_s) begin
         rd_addr_s = pix_addr(rd_x_s, rd_y_s);
      end else begin
         rd_addr_s = {ADDR_W{1'b0}};
      end
   end

   // Read pipeline. Stage 1 captures the address, the flag and the front
   // index. Stage 2 reads the buffer chosen by that captured index, so a swap
   // between stages cannot redirect an in-flight read. Later stages only
   // delay the data. Sync signals travel alongside through the same number
   // of stages.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_addr_r  <= {ADDR_W{1'b0}};
         rd_front_r <= 1'b0;
         for (int k = 0; k < LATENCY - 1; k++) begin
            flag_pipe_r[k] <= 1'b0;
            pix_pipe_r[k]  <= BG_COLOR;
         end
         for (int k = 0; k < LATENCY; k++) begin
            hs_pipe_r[k] <= 1'b0;
            vs_pipe_r[k] <= 1'b0;
         end
      end else begin
         rd_addr_r      <= rd_addr_s;
         rd_front_r     <= front_r;
         flag_pipe_r[0] <= rd_in_s;
         hs_pipe_r[0]   <= rd_hsync;
         vs_pipe_r[0]   <= rd_vsync;
         // Stage 2: buffer read, blanked to background outside the region.
         // The old word is returned on a same-cycle write (read-first).
         if (flag_pipe_r[0]) begin
            pix_pipe_r[0] <= mem_r[rd_front_r][rd_addr_r];
         end else begin
            pix_pipe_r[0] <= BG_COLOR;
         end
         for (int j = 1; j < LATENCY - 1; j++) begin
            flag_pipe_r[j] <= flag_pipe_r[j-1];
            if (flag_pipe_r[j]) begin
               pix_pipe_r[j] <= pix_pipe_r[j-1];
            end else begin
               pix_pipe_r[j] <= BG_COLOR;
            end
         end
         for (int k = 1; k < LATENCY; k++) begin
            hs_pipe_r[k] <= hs_pipe_r[k-1];
            vs_pipe_r[k] <= vs_pipe_r[k-1];
         end
      end
   end

   assign wr_ready  = wr_ready_r;
   assign swap_out  = swap_r;
   assign front_out = front_r;
   assign pix_out   = pix_pipe_r[LATENCY-2];
   assign hs_out    = hs_pipe_r[LATENCY-1];
   assign vs_out    = vs_pipe_r[LATENCY-1];

endmodule

// File: tb/tb_render_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_render_framebuffer
//
// Purpose:
//   Directed and randomized bench for render_framebuffer.
//   Two instances share all inputs: one with LATENCY=2 and one with
//   LATENCY=5. Expected values come from a frame-level model kept in the
//   bench:
//   - two pixel arrays, indexed by region offset;
//   - the front index and the swap-armed flag;
//   - per-instance queues that delay the expected pixel and sync values.
// -----------------------------------------------------------------------------
module tb_render_framebuffer;

   localparam logic [11:0] BG = 12'hF00;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        wr_valid;
   logic [10:0] wr_hcount;
   logic [9:0]  wr_vcount;
   logic [11:0] wr_data;
   logic [10:0] rd_hcount;
   logic [9:0]  rd_vcount;
   logic        rd_active, rd_hsync, rd_vsync, nf_in;

   logic [11:0] pix2, pix5;
   logic        ready2, ready5, hs2, hs5, vs2, vs5, swap2, swap5, front2, front5;

   int tests = 0;
   int fails = 0;
   bit rand_rd = 1'b0;

   // Frame-level model state.
   logic [11:0] mem_m [2][12];
   bit          front_m, pend_m;
   logic [11:0] q2[$], q5[$];
   bit          hq2[$], hq5[$], vq2[$], vq5[$];

   always #5 clk = ~clk;

   render_framebuffer #(
      .START_X(4), .START_Y(2), .WIDTH(4), .HEIGHT(3), .PIXEL_W(12),
      .LATENCY(2), .DOUBLE_BUF(1), .BG_COLOR(12'hF00)
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .wr_valid(wr_valid), .wr_ready(ready2),
      .wr_hcount(wr_hcount), .wr_vcount(wr_vcount), .wr_data(wr_data),
      .rd_hcount(rd_hcount), .rd_vcount(rd_vcount), .rd_active(rd_active),
      .rd_hsync(rd_hsync), .rd_vsync(rd_vsync), .nf_in(nf_in),
      .pix_out(pix2), .hs_out(hs2), .vs_out(vs2), .swap_out(swap2), .front_out(front2)
   );

   render_framebuffer #(
      .START_X(4), .START_Y(2), .WIDTH(4), .HEIGHT(3), .PIXEL_W(12),
      .LATENCY(5), .DOUBLE_BUF(1), .BG_COLOR(12'hF00)
   ) dut5 (
      .clk_in(clk), .rst_in(rst_in), .wr_valid(wr_valid), .wr_ready(ready5),
      .wr_hcount(wr_hcount), .wr_vcount(wr_vcount), .wr_data(wr_data),
      .rd_hcount(rd_hcount), .rd_vcount(rd_vcount), .rd_active(rd_active),
      .rd_hsync(rd_hsync), .rd_vsync(rd_vsync), .nf_in(nf_in),
      .pix_out(pix5), .hs_out(hs5), .vs_out(vs5), .swap_out(swap5), .front_out(front5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit inreg(input int x, input int y);
      return (x >= 4) && (x < 8) && (y >= 2) && (y < 5);
   endfunction

   function automatic int pidx(input int x, input int y);
      return (x - 4) + (y - 2) * 4;
   endfunction

   // Reset the model: control state cleared, pipelines full of background.
   task automatic model_reset();
      front_m = 1'b0;
      pend_m  = 1'b0;
      q2.delete(); q5.delete(); hq2.delete(); hq5.delete(); vq2.delete(); vq5.delete();
      q2.push_back(BG); hq2.push_back(1'b0); vq2.push_back(1'b0);
      for (int i = 0; i < 4; i++) begin
         q5.push_back(BG); hq5.push_back(1'b0); vq5.push_back(1'b0);
      end
   endtask

   // One clock cycle with the current inputs. The model predicts the cycle,
   // then every output of both instances is compared after the edge.
   task automatic step();
      bit fire, inr, last, sw, rin;
      logic [11:0] e, ep;
      bit eh, ev;
      int wx, wy, rx, ry;
      if (rand_rd) begin
         rd_hcount = 11'($urandom_range(0, 10));
         rd_vcount = 10'($urandom_range(0, 7));
         rd_active = 1'($urandom_range(0, 1));
         rd_hsync  = 1'($urandom_range(0, 1));
         rd_vsync  = 1'($urandom_range(0, 1));
      end
      wx   = int'(wr_hcount);
      wy   = int'(wr_vcount);
      rx   = int'(rd_hcount);
      ry   = int'(rd_vcount);
      fire = wr_valid && !pend_m;
      inr  = inreg(wx, wy);
      last = fire && (wx == 7) && (wy == 4);
      sw   = nf_in && (pend_m || last);
      rin  = rd_active && inreg(rx, ry);
      e    = BG;
      if (rin) e = mem_m[front_m][pidx(rx, ry)];
      q2.push_back(e); q5.push_back(e);
      hq2.push_back(rd_hsync); hq5.push_back(rd_hsync);
      vq2.push_back(rd_vsync); vq5.push_back(rd_vsync);
      @(posedge clk); #1;
      if (fire && inr) mem_m[!front_m][pidx(wx, wy)] = wr_data;
      if (sw) begin
         pend_m  = 1'b0;
         front_m = !front_m;
      end else if (last) begin
         pend_m = 1'b1;
      end
      chk("swap_out", 32'(swap2), 32'(sw));
      chk("front_out", 32'(front2), 32'(front_m));
      chk("wr_ready", 32'(ready2), 32'(!pend_m));
      ep = q2.pop_front(); chk("pix_out", 32'(pix2), 32'(ep));
      eh = hq2.pop_front(); chk("hs_out", 32'(hs2), 32'(eh));
      ev = vq2.pop_front(); chk("vs_out", 32'(vs2), 32'(ev));
      chk("swap_out_l5", 32'(swap5), 32'(sw));
      chk("front_out_l5", 32'(front5), 32'(front_m));
      chk("wr_ready_l5", 32'(ready5), 32'(!pend_m));
      ep = q5.pop_front(); chk("pix_out_l5", 32'(pix5), 32'(ep));
      eh = hq5.pop_front(); chk("hs_out_l5", 32'(hs5), 32'(eh));
      ev = vq5.pop_front(); chk("vs_out_l5", 32'(vs5), 32'(ev));
   endtask

   task automatic wr_px(input int x, input int y, input logic [11:0] d, input bit nf);
      wr_valid  = 1'b1;
      wr_hcount = 11'(x);
      wr_vcount = 10'(y);
      wr_data   = d;
      nf_in     = nf;
      step();
      wr_valid  = 1'b0;
      nf_in     = 1'b0;
   endtask

   task automatic pulse_nf();
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
   endtask

   // Write all 12 region pixels in raster order.
   // mode 0 writes x+16*y; otherwise random data is written.
   // With oor set, out-of-region writes are slipped in before the last pixel.
   task automatic frame(input int mode, input bit coincide, input bit oor, input bit idles);
      int i;
      logic [11:0] d;
      i = 0;
      for (int y = 2; y < 5; y++) begin
         for (int x = 4; x < 8; x++) begin
            if (idles && ($urandom_range(0, 3) == 0)) begin
               nf_in = 1'($urandom_range(0, 1));
               step();
               nf_in = 1'b0;
            end
            if (oor && (i == 11)) begin
               wr_px(8, 2, 12'h5A5, 1'b0);
               wr_px(3, 3, 12'hA5A, 1'b0);
               wr_px(4, 5, 12'h3C3, 1'b0);
            end
            if (oor && ($urandom_range(0, 3) == 0)) begin
               wr_px(8 + int'($urandom_range(0, 6)), int'($urandom_range(0, 9)), 12'($urandom), 1'b0);
            end
            if (mode == 0) d = 12'(x + 16 * y);
            else           d = 12'($urandom);
            wr_px(x, y, d, coincide && (x == 7) && (y == 4));
            i++;
         end
      end
   endtask

   task automatic read_chk(input int x, input int y, input logic [11:0] exp, input string tag);
      rd_hcount = 11'(x);
      rd_vcount = 10'(y);
      rd_active = 1'b1;
      step();
      step();
      chk(tag, 32'(pix2), 32'(exp));
      rd_active = 1'b0;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst_in = 1'b1;
      #1;
      chk("rst_front", 32'(front2), 32'd0);
      chk("rst_swap", 32'(swap2), 32'd0);
      chk("rst_hs", 32'(hs2), 32'd0);
      chk("rst_vs", 32'(vs2), 32'd0);
      chk("rst_pix", 32'(pix2), 32'(BG));
      chk("rst_pix_l5", 32'(pix5), 32'(BG));
      chk("rst_front_l5", 32'(front5), 32'd0);
      @(posedge clk); #1;
      rst_in = 1'b0;
      model_reset();
      chk("rst_ready", 32'(ready2), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst_in = 1'b1; wr_valid = 1'b0; wr_hcount = 11'd0; wr_vcount = 10'd0; wr_data = 12'd0;
      rd_hcount = 11'd0; rd_vcount = 10'd0; rd_active = 1'b0; rd_hsync = 1'b0; rd_vsync = 1'b0;
      nf_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_front", 32'(front2), 32'd0);
      chk("init_swap", 32'(swap2), 32'd0);
      chk("init_pix", 32'(pix2), 32'(BG));
      rst_in = 1'b0;
      model_reset();
      chk("init_ready", 32'(ready2), 32'd1);

      // Frame A: x+16*y, then a new-frame pulse swaps it to the display.
      frame(0, 1'b0, 1'b0, 1'b0);
      chk("last_ready_low", 32'(ready2), 32'd0);
      pulse_nf();
      chk("a_swap", 32'(swap2), 32'd1);
      chk("a_front", 32'(front2), 32'd1);
      step();
      chk("a_swap_once", 32'(swap2), 32'd0);
      read_chk(5, 3, 12'h035, "read_5_3");
      read_chk(3, 3, 12'hF00, "read_3_3");

      // Frame B: random data. Then hold a write while the swap is armed.
      frame(1, 1'b0, 1'b0, 1'b0);
      chk("b_ready_low", 32'(ready2), 32'd0);
      wr_valid = 1'b1; wr_hcount = 11'd4; wr_vcount = 10'd2; wr_data = 12'hABC;
      repeat (3) step();
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
      chk("b_swap_after_hold", 32'(swap2), 32'd1);
      chk("b_ready_back", 32'(ready2), 32'd1);
      step();
      wr_valid = 1'b0;

      // From here both buffers hold written data, so random display reads are safe.
      rand_rd = 1'b1;

      // Frame C: the last-pixel write and the new-frame pulse coincide.
      frame(0, 1'b1, 1'b0, 1'b0);
      chk("c_coincide_swap", 32'(swap2), 32'd1);
      rand_rd = 1'b0;
      read_chk(7, 4, 12'h047, "read_7_4");

      // Frame D: out-of-region writes, including (8,2), land nowhere.
      // A stray new-frame pulse must do nothing.
      wr_px(8, 2, 12'h777, 1'b0);
      chk("oor_ready", 32'(ready2), 32'd1);
      pulse_nf();
      chk("oor_no_swap", 32'(swap2), 32'd0);
      frame(1, 1'b0, 1'b1, 1'b0);
      pulse_nf();
      for (int y = 2; y < 5; y++) begin
         for (int x = 4; x < 8; x++) begin
            rd_hcount = 11'(x); rd_vcount = 10'(y); rd_active = 1'b1;
            step();
         end
      end
      rd_active = 1'b0;
      step(); step();

      // Randomized frames with idles, stray pulses, stray writes and reads.
      rand_rd = 1'b1;
      for (int f = 0; f < 6; f++) begin
         bit co;
         co = 1'($urandom_range(0, 1));
         frame(1, co, 1'b1, 1'b1);
         if (!co) begin
            repeat ($urandom_range(0, 2)) begin
               wr_valid = 1'($urandom_range(0, 1));
               wr_hcount = 11'd5; wr_vcount = 10'd3; wr_data = 12'($urandom);
               step();
               wr_valid = 1'b0;
            end
            pulse_nf();
         end
         repeat (3) step();
      end

      // Sync latency on the LATENCY=5 instance: one hsync pulse in, and it
      // must appear exactly five edges later.
      rand_rd = 1'b0;
      rd_active = 1'b1; rd_hcount = 11'd5; rd_vcount = 10'd3; rd_hsync = 1'b0; rd_vsync = 1'b0;
      repeat (6) step();
      rd_hsync = 1'b1;
      step();
      rd_hsync = 1'b0;
      seen = 0;
      for (int k = 2; k <= 8; k++) begin
         step();
         if ((hs5 === 1'b1) && (seen == 0)) seen = k;
      end
      chk("hs_l5_delay", 32'(seen), 32'd5);
      rd_active = 1'b0;

      // Reset after 6 writes: the partial frame is abandoned.
      for (int i = 0; i < 6; i++) begin
         wr_px(4 + (i % 4), 2 + (i / 4), 12'($urandom), 1'b0);
      end
      do_reset();
      pulse_nf();
      chk("rst_no_swap", 32'(swap2), 32'd0);
      chk("rst_front0", 32'(front2), 32'd0);
      step(); step();
      chk("rst_pix_bg", 32'(pix2), 32'(BG));
      frame(1, 1'b0, 1'b0, 1'b0);
      pulse_nf();
      chk("rst_full_frame_swap", 32'(swap2), 32'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
